// File: rtl/io_readback_hub_pkg.sv
// Shared constants for the top-level I/O readback wrappers: function codes,
// error word layout, status codes and the readback FSM state type.
package io_readback_hub_pkg;

  localparam logic [3:0]  FC_STUB_TAGGING    = 4'h2;
  localparam logic [3:0]  FC_TRACKLET_SEARCH = 4'h4;
  localparam logic [3:0]  FC_TRACK_PARAMS    = 4'h5;

  localparam logic [31:0] ERR_WORD_BASE = 32'hBAD0_0000;
  localparam logic [7:0]  ST_UNMAPPED   = 8'h01;
  localparam logic [3:0]  ST_TIMEOUT_HI = 4'h8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } hub_state_e;

  function automatic logic [31:0] err_word(input logic [31:0] base,
                                           input logic [7:0]  status);
    return (base & 32'hFFFF_FF00) | {24'h0, status};
  endfunction

endpackage

// File: rtl/io_code_decoder.sv
// Function-code to one-hot channel decoder; the lowest-index channel wins when
// several channels share a code.
module io_code_decoder
  import io_readback_hub_pkg::*;
#(
  parameter int                N_CH     = 4,
  parameter logic [4*N_CH-1:0] CH_CODES = {4'h6, FC_TRACK_PARAMS,
                                           FC_TRACKLET_SEARCH, FC_STUB_TAGGING}
) (
  input  logic            en,
  input  logic [3:0]      code,
  output logic [N_CH-1:0] onehot,
  output logic [3:0]      idx,
  output logic            match
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    match  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!match && (code == CH_CODES[4*k +: 4])) begin
        match     = 1'b1;
        idx       = 4'(k);
        onehot[k] = en;
      end
    end
  end

endmodule

// File: rtl/io_readback_hub.sv
// I/O readback hub: decodes the function code onto channel selects, tracks one
// outstanding read and returns data or a timeout/unmapped error word.
module io_readback_hub
  import io_readback_hub_pkg::*;
#(
  parameter int                N_CH     = 4,
  parameter logic [4*N_CH-1:0] CH_CODES = {4'h6, FC_TRACK_PARAMS,
                                           FC_TRACKLET_SEARCH, FC_STUB_TAGGING},
  parameter int                TIMEOUT  = 256,
  parameter logic [31:0]       ERR_WORD = ERR_WORD_BASE
) (
  input  logic               io_clk,
  input  logic               reset,
  input  logic               io_sel,
  input  logic               io_sync,
  input  logic [19:0]        io_addr,
  input  logic               io_rd_en,
  input  logic               io_wr_en,
  output logic [N_CH-1:0]    ch_sel,
  output logic [15:0]        ch_addr,
  input  logic [32*N_CH-1:0] ch_rd_data,
  input  logic [N_CH-1:0]    ch_rd_ack,
  output logic [31:0]        io_rd_data,
  output logic               io_rd_ack,
  output logic               busy,
  output logic [15:0]        timeout_cnt
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  logic [N_CH-1:0] dec_onehot;
  logic [3:0]      dec_idx;
  logic            dec_match;

  io_code_decoder #(
    .N_CH     (N_CH),
    .CH_CODES (CH_CODES)
  ) u_dec (
    .en     (io_sel),
    .code   (io_addr[19:16]),
    .onehot (dec_onehot),
    .idx    (dec_idx),
    .match  (dec_match)
  );

  assign ch_sel  = dec_onehot;
  assign ch_addr = io_addr[15:0];

  // Writes need no response, so the write strobe never reaches the FSM.
  logic unused_wr_en;
  assign unused_wr_en = io_wr_en;

  hub_state_e  state_q, state_d;
  logic [3:0]  ch_idx_q, ch_idx_d;
  logic [15:0] timer_q, timer_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_ack_q, rd_ack_d;
  logic        busy_q, busy_d;
  logic [15:0] timeout_cnt_q, timeout_cnt_d;

  logic [3:0]  sel_idx;
  logic [31:0] sel_data;
  logic        sel_ack;
  logic        start;
  logic        err_inc;

  assign start = io_sync & io_sel & io_rd_en;

  // In IDLE the live decode picks the channel; afterwards the latched index does.
  always_comb begin
    sel_idx  = (state_q == IDLE) ? dec_idx : ch_idx_q;
    sel_data = '0;
    sel_ack  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_idx == 4'(k)) begin
        sel_data = ch_rd_data[32*k +: 32];
        sel_ack  = ch_rd_ack[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_idx_d  = ch_idx_q;
    timer_d   = timer_q;
    rd_data_d = rd_data_q;
    rd_ack_d  = 1'b0;
    busy_d    = busy_q;
    err_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!dec_match) begin
            rd_data_d = err_word(ERR_WORD, ST_UNMAPPED);
            err_inc   = 1'b1;
            rd_ack_d  = 1'b1;
            state_d   = RESP;
          end else if (sel_ack) begin
            rd_data_d = sel_data;
            rd_ack_d  = 1'b1;
            state_d   = RESP;
          end else begin
            ch_idx_d = dec_idx;
            timer_d  = '0;
            busy_d   = 1'b1;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        // A real ack on the expiry cycle takes precedence over the error.
        if (sel_ack) begin
          rd_data_d = sel_data;
          rd_ack_d  = 1'b1;
          busy_d    = 1'b0;
          state_d   = RESP;
        end else if (timer_q == TIMER_LAST) begin
          rd_data_d = err_word(ERR_WORD, {ST_TIMEOUT_HI, ch_idx_q});
          err_inc   = 1'b1;
          rd_ack_d  = 1'b1;
          busy_d    = 1'b0;
          state_d   = RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    timeout_cnt_d = (err_inc && (timeout_cnt_q != 16'hFFFF)) ?
                    timeout_cnt_q + 16'd1 : timeout_cnt_q;
  end

  always_ff @(posedge io_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ch_idx_q      <= '0;
      timer_q       <= '0;
      rd_data_q     <= '0;
      rd_ack_q      <= 1'b0;
      busy_q        <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      ch_idx_q      <= ch_idx_d;
      timer_q       <= timer_d;
      rd_data_q     <= rd_data_d;
      rd_ack_q      <= rd_ack_d;
      busy_q        <= busy_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign io_rd_data  = rd_data_q;
  assign io_rd_ack   = rd_ack_q;
  assign busy        = busy_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule
